// File: rtl/smem_mem_drainer.sv
// Drains finished SMEM reads: queues finish events, reads mem entries back and packs 512-bit lines.
// Optional macro SMEM_DRAIN_CNT_EN enables the drained_lines counter.
//   state | meaning
//   IDLE  | wait for a queued job, pop it into jnum/jsize
//   HDR   | present header line {jsize, jnum}
//   RD_LO | read entry idx
//   RD_HI | capture low entry, read entry idx+1 if it exists
//   CAP   | capture high entry (or zero pad)
//   OUT   | present data line, advance idx by two on accept
module smem_mem_drainer #(
    parameter int READ_NUM_WIDTH = 9,
    parameter int JOB_DEPTH      = 8,
    parameter int ADDR_W         = 7
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      finish_sign,
    input  logic [READ_NUM_WIDTH-1:0] finish_read_num,
    input  logic [ADDR_W-1:0]         finish_mem_size,
    output logic                      rd_en,
    output logic [READ_NUM_WIDTH-1:0] rd_read_num,
    output logic [ADDR_W-1:0]         rd_addr,
    input  logic [255:0]              rd_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [511:0]              out_data,
    output logic                      out_last,
    output logic [READ_NUM_WIDTH-1:0] out_read_num,
    output logic                      job_overflow,
    output logic [31:0]               drained_lines
);

    localparam int PTR_W = $clog2(JOB_DEPTH);
    localparam int JOB_W = READ_NUM_WIDTH + ADDR_W;

    typedef enum logic [2:0] {IDLE, HDR, RD_LO, RD_HI, CAP, OUT} state_t;

    state_t state, state_nx;

    logic [JOB_W-1:0]          q_mem [JOB_DEPTH];
    logic [PTR_W-1:0]          q_wr, q_rd;
    logic [PTR_W:0]            q_cnt;
    logic                      push, pop;

    logic [READ_NUM_WIDTH-1:0] jnum;
    logic [ADDR_W-1:0]         jsize;
    logic [ADDR_W:0]           idx, idx_p1, idx_p2, jsize_x;
    logic [255:0]              lo, hi;
    logic                      hi_pending, hi_issue;
    logic [ADDR_W-1:0]         rd_addr_q;
    logic [READ_NUM_WIDTH-1:0] rd_num_q;

    assign pop     = (state == IDLE) && (q_cnt != '0);
    assign push    = finish_sign && ((q_cnt != (PTR_W+1)'(JOB_DEPTH)) || pop);
    assign idx_p1  = idx + 1'b1;
    assign idx_p2  = idx + 2'd2;
    assign jsize_x = {1'b0, jsize};
    assign hi_issue = idx_p1 < jsize_x;

    always_ff @(posedge clk) begin
        if (push)
            q_mem[q_wr] <= {finish_mem_size, finish_read_num};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_wr         <= '0;
            q_rd         <= '0;
            q_cnt        <= '0;
            job_overflow <= 1'b0;
        end else begin
            if (push) q_wr <= q_wr + 1'b1;
            if (pop)  q_rd <= q_rd + 1'b1;
            case ({push, pop})
                2'b10:   q_cnt <= q_cnt + 1'b1;
                2'b01:   q_cnt <= q_cnt - 1'b1;
                default: q_cnt <= q_cnt;
            endcase
            if (finish_sign && !push) job_overflow <= 1'b1;
        end
    end

    always_comb begin
        state_nx     = state;
        rd_en        = 1'b0;
        rd_addr      = rd_addr_q;
        rd_read_num  = rd_num_q;
        out_valid    = 1'b0;
        out_data     = '0;
        out_last     = 1'b0;
        out_read_num = '0;
        case (state)
            IDLE: if (q_cnt != '0) state_nx = HDR;
            HDR: begin
                out_valid              = 1'b1;
                out_data[JOB_W-1:0]    = {jsize, jnum};
                out_last               = (jsize == '0);
                out_read_num           = jnum;
                if (out_ready) state_nx = (jsize == '0) ? IDLE : RD_LO;
            end
            RD_LO: begin
                rd_en       = 1'b1;
                rd_addr     = idx[ADDR_W-1:0];
                rd_read_num = jnum;
                state_nx    = RD_HI;
            end
            RD_HI: begin
                if (hi_issue) begin
                    rd_en       = 1'b1;
                    rd_addr     = idx_p1[ADDR_W-1:0];
                    rd_read_num = jnum;
                end
                state_nx = CAP;
            end
            CAP: state_nx = OUT;
            OUT: begin
                out_valid    = 1'b1;
                out_data     = {hi, lo};
                out_last     = (idx_p2 >= jsize_x);
                out_read_num = jnum;
                if (out_ready) state_nx = (idx_p2 >= jsize_x) ? IDLE : RD_LO;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            jnum       <= '0;
            jsize      <= '0;
            idx        <= '0;
            lo         <= '0;
            hi         <= '0;
            hi_pending <= 1'b0;
            rd_addr_q  <= '0;
            rd_num_q   <= '0;
        end else begin
            state <= state_nx;
            if (pop) begin
                {jsize, jnum} <= q_mem[q_rd];
                idx           <= '0;
            end
            if (state == RD_HI) begin
                lo         <= rd_data;
                hi_pending <= hi_issue;
            end
            if (state == CAP) hi <= hi_pending ? rd_data : '0;
            if (state == OUT && out_ready) idx <= idx_p2;
            if (rd_en) begin
                rd_addr_q <= rd_addr;
                rd_num_q  <= rd_read_num;
            end
        end
    end

`ifdef SMEM_DRAIN_CNT_EN
    logic [31:0] line_cnt;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            line_cnt <= '0;
        else if (out_valid && out_ready)
            line_cnt <= line_cnt + 1'b1;
    end
    assign drained_lines = line_cnt;
`else
    assign drained_lines = '0;
`endif

endmodule

// File: tb/tb_smem_mem_drainer.sv
// Scoreboard bench for smem_mem_drainer: expected lines and read addresses are queued as jobs are sent.
module tb_smem_mem_drainer;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         finish_sign = 1'b0;
    logic [8:0]   finish_read_num = '0;
    logic [6:0]   finish_mem_size = '0;
    logic         rd_en;
    logic [8:0]   rd_read_num;
    logic [6:0]   rd_addr;
    logic [255:0] rd_data;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [511:0] out_data;
    logic         out_last;
    logic [8:0]   out_read_num;
    logic         job_overflow;
    logic [31:0]  drained_lines;

    typedef struct {
        logic [511:0] data;
        logic         last;
        logic [8:0]   num;
    } line_t;

    line_t       exp_q[$];
    logic [15:0] addr_q[$];
    int          n_vec  = 0;
    int          n_miss = 0;
    logic [511:0] snap;

    smem_mem_drainer dut (
        .clk(clk), .rst(rst),
        .finish_sign(finish_sign), .finish_read_num(finish_read_num),
        .finish_mem_size(finish_mem_size),
        .rd_en(rd_en), .rd_read_num(rd_read_num), .rd_addr(rd_addr), .rd_data(rd_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .out_read_num(out_read_num),
        .job_overflow(job_overflow), .drained_lines(drained_lines)
    );

    always #5 clk = ~clk;

    function automatic logic [255:0] entry(input logic [8:0] n, input logic [6:0] a);
        logic [255:0] r;
        for (int k = 0; k < 8; k++) r[k*32 +: 32] = {4'(k), 3'b000, n, 1'b0, a, 8'h5a};
        return r;
    endfunction

    // storage model: data appears exactly one cycle after rd_en, garbage otherwise
    always @(posedge clk or negedge rst) begin
        if (!rst)       rd_data <= '0;
        else if (rd_en) rd_data <= entry(rd_read_num, rd_addr);
        else            rd_data <= {8{32'hdeadbeef}};
    end

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (rd_en) begin
                if (addr_q.size() == 0) chk("rd_unexp", 512'(rd_en), 512'(0));
                else chk("rd_addr", 512'({rd_read_num, rd_addr}), 512'(addr_q.pop_front()));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) chk("line_unexp", 512'(out_valid), 512'(0));
                else begin
                    line_t e;
                    e = exp_q.pop_front();
                    chk("line_data", out_data, e.data);
                    chk("line_last", 512'(out_last), 512'(e.last));
                    chk("line_num", 512'(out_read_num), 512'(e.num));
                end
            end
        end
    end

    task automatic send_job(input logic [8:0] n, input logic [6:0] s, input bit drop);
        line_t l;
        @(posedge clk); #1;
        finish_sign     = 1'b1;
        finish_read_num = n;
        finish_mem_size = s;
        if (!drop) begin
            l.data = 512'({s, n});
            l.last = (s == 0);
            l.num  = n;
            exp_q.push_back(l);
            for (int i = 0; i < int'(s); i += 2) begin
                l.data[255:0]   = entry(n, 7'(i));
                l.data[511:256] = (i + 1 < int'(s)) ? entry(n, 7'(i + 1)) : '0;
                l.last          = (i + 2 >= int'(s));
                exp_q.push_back(l);
            end
            for (int i = 0; i < int'(s); i++) addr_q.push_back({n, 7'(i)});
        end
        @(posedge clk); #1;
        finish_sign = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && addr_q.size() == 0) break;
        end
        chk("drain_pending", 512'(exp_q.size() + addr_q.size()), 512'(0));
    endtask

    task automatic wait_valid();
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        chk("wait_valid", 512'(out_valid), 512'(1));
    endtask

    task automatic accept_header();
        @(posedge clk); #1 out_ready = 1'b1;
        @(posedge clk); #1 out_ready = 1'b0;
    endtask

    initial begin
        #12;
        chk("rst_valid", 512'(out_valid), 512'(0));
        chk("rst_data", out_data, 512'(0));
        chk("rst_rd_en", 512'(rd_en), 512'(0));
        chk("rst_rd_addr", 512'({rd_read_num, rd_addr}), 512'(0));
        chk("rst_last_num", 512'({out_last, out_read_num}), 512'(0));
        chk("rst_ovf", 512'(job_overflow), 512'(0));
        chk("rst_cnt", 512'(drained_lines), 512'(0));
        @(negedge clk) rst = 1'b1;

        // basic job, then an empty job
        send_job(9'd5, 7'd3, 1'b0);
        wait_idle(200);
        send_job(9'd17, 7'd0, 1'b0);
        wait_idle(200);

        // backpressure on a data line
        out_ready = 1'b0;
        send_job(9'd33, 7'd4, 1'b0);
        wait_valid();
        accept_header();
        wait_valid();
        snap = out_data;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("bp_valid", 512'(out_valid), 512'(1));
            chk("bp_data", out_data, snap);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        wait_idle(300);

        // queue overflow while first job stalls in HDR
        out_ready = 1'b0;
        send_job(9'd100, 7'd2, 1'b0);
        wait_valid();
        for (int i = 0; i < 9; i++) send_job(9'(200 + i), 7'(i % 3 + 1), i == 8);
        chk("ovf_set", 512'(job_overflow), 512'(1));
        @(posedge clk); #1 out_ready = 1'b1;
        wait_idle(1000);
        chk("ovf_sticky", 512'(job_overflow), 512'(1));
        @(negedge clk) rst = 1'b0;
        #2 chk("ovf_rst", 512'(job_overflow), 512'(0));
        @(negedge clk) rst = 1'b1;

        // full queue with a push in the same cycle as a pop
        out_ready = 1'b0;
        send_job(9'd300, 7'd0, 1'b0);
        wait_valid();
        for (int i = 0; i < 8; i++) send_job(9'(310 + i), 7'd2, 1'b0);
        @(posedge clk); #1 out_ready = 1'b1;
        send_job(9'd320, 7'd3, 1'b0);
        chk("ovf_none", 512'(job_overflow), 512'(0));
        wait_idle(1000);

        // reset while a data line is pending
        out_ready = 1'b0;
        send_job(9'd400, 7'd4, 1'b0);
        wait_valid();
        accept_header();
        wait_valid();
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_valid", 512'(out_valid), 512'(0));
        chk("mid_rst_data", out_data, 512'(0));
        chk("mid_rst_misc", 512'({rd_en, out_last, out_read_num}), 512'(0));
        exp_q.delete();
        addr_q.delete();
        @(negedge clk);
        @(negedge clk) rst = 1'b1;
        out_ready = 1'b1;
        repeat (20) @(negedge clk);

        send_job(9'd7, 7'd3, 1'b0);
        send_job(9'd8, 7'd4, 1'b0);
        wait_idle(300);
`ifdef SMEM_DRAIN_CNT_EN
        chk("drained_lines", 512'(drained_lines), 512'(6));
`else
        chk("drained_lines", 512'(drained_lines), 512'(0));
`endif

        for (int j = 0; j < 6; j++)
            send_job(9'($urandom_range(0, 511)), 7'($urandom_range(0, 127)), 1'b0);
        wait_idle(5000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/smem_mem_drainer.md
Name: smem_mem_drainer

Overview:
- Back-end reader for the SMEM storage unit.
- The backward control pipeline writes mem entries (x0, x1, x2, info) per read and then pulses finish_sign with read_num and mem_size.
- This block queues those finish events, reads each read's mem entries back from storage, and packs them into 512-bit cache lines for the host write-back path.
- Each job emits one header line followed by data lines at two entries per line.

Parameters:
READ_NUM_WIDTH, 9, width of read number
JOB_DEPTH, 8, finish-event queue depth (power of two)
ADDR_W, 7, mem storage address width / mem_size width

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-low reset
finish_sign  input  1  one-cycle pulse: read finished, enqueue job
finish_read_num  input  READ_NUM_WIDTH  read number of finished read
finish_mem_size  input  ADDR_W  number of mem entries stored for that read (0..127)
rd_en  output  1  storage read strobe
rd_read_num  output  READ_NUM_WIDTH  read number being drained
rd_addr  output  ADDR_W  mem entry index
rd_data  input  256  {info, x2, x1, x0}; valid exactly 1 cycle after rd_en
out_valid  output  1  output line valid
out_ready  input  1  downstream accepts line
out_data  output  512  packed line
out_last  output  1  final line of current job
out_read_num  output  READ_NUM_WIDTH  job read number, valid with out_valid
job_overflow  output  1  sticky: finish event dropped
drained_lines  output  32  lines emitted (see Optional Feature)

Behaviour:
- Reset asserted (rst=0, async) clears all state immediately:
  - every output reads 0; FSM returns to IDLE; job queue empties; any in-flight job is lost.
- Job queue:
  - FIFO of {read_num, mem_size}.
  - Push on finish_sign if count<JOB_DEPTH, or if count==JOB_DEPTH and a pop occurs in the same cycle.
  - Otherwise the event is dropped and job_overflow is set; it stays set until reset.
- FSM states: IDLE, HDR, RD_LO, RD_HI, CAP, OUT.
- IDLE:
  - If the queue is non-empty: pop the head into job regs (jnum, jsize), clear idx=0, go to HDR.
- HDR:
  - out_valid=1; out_data = {zeros, jsize (ADDR_W bits at [ADDR_W+READ_NUM_WIDTH-1:READ_NUM_WIDTH]), jnum at [READ_NUM_WIDTH-1:0]}.
  - out_last = (jsize==0).
  - On out_valid&out_ready: go to IDLE if jsize==0, else to RD_LO.
- RD_LO:
  - rd_en=1, rd_addr=idx, rd_read_num=jnum. Go to RD_HI.
- RD_HI:
  - Capture rd_data into the low half.
  - If idx+1<jsize: rd_en=1, rd_addr=idx+1, and flag hi_pending.
  - Go to CAP.
- CAP:
  - Capture rd_data into the high half if hi_pending, else load zero. Go to OUT.
- OUT:
  - out_valid=1; out_data={hi,lo}; out_last=(idx+2>=jsize).
  - Hold data stable while out_ready=0.
  - On accept: idx+=2 (ADDR_W+1-bit arithmetic, no wrap); go to IDLE if last, else to RD_LO.
- rd_en is 0 in all other states. rd_addr and rd_read_num hold their last values when rd_en=0.
- out_valid is 0 outside HDR and OUT. out_valid must not drop without acceptance.
- Lines per job: 1 + ceil(jsize/2). Odd jsize zero-pads the upper 256 bits of the final line.
- A finish_sign arriving while a job drains is only queued; it never preempts the job.
- Minimum per-data-line latency from RD_LO to out_valid is 3 cycles.

Optional Feature:
- Macro SMEM_DRAIN_CNT_EN.
- Defined: drained_lines is a 32-bit counter, incremented on every out_valid&out_ready (header and data lines). It wraps at 2^32 and is cleared by reset.
- Undefined: drained_lines is tied to 0 and no counter logic exists.

Test Plan:
- Single job, finish_read_num=5, mem_size=3, out_ready=1:
  - header carries num 5, size 3.
  - Line 1 = entries 0,1; line 2 = entry 2 with upper 256 bits zero; out_last only on line 2.
  - rd_addr sequence 0,1,2.
- mem_size=0 job:
  - exactly one header line with out_last=1; rd_en never asserted.
- Backpressure:
  - out_ready=0 for 10 cycles during OUT: out_valid and out_data held constant, no extra rd_en.
  - After release, the line is emitted once.
- Queue fill:
  - 9 finish pulses (JOB_DEPTH=8) while the first job is stalled: 9th dropped, job_overflow=1.
  - Jobs 1-8 drain in order.
  - Repeat with a pop in the same cycle as the 9th push: no drop.
- Reset mid-job:
  - rst=0 while in OUT: outputs go to 0 immediately.
  - After release, no residual lines appear; a new job drains correctly.
- With SMEM_DRAIN_CNT_EN: jobs of size 3 and 4 give drained_lines=6. Without the macro: drained_lines stays 0.
